// File: rtl/trace_capture_ctrl_pkg.sv
// Shared definitions for the trace capture sequencer: state encoding and
// the address/counter width helper.
package trace_capture_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRE_FILL = 3'd1,
        ST_ARMED    = 3'd2,
        ST_POST     = 3'd3,
        ST_READOUT  = 3'd4
    } state_t;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ram_1c_1r_1w.sv
// Single-clock simple dual-port RAM: one write port, one read port with a
// registered (1-cycle latency) read. Contents are not reset.
module ram_1c_1r_1w
    import trace_capture_ctrl_pkg::*;
#(
    parameter int Width = 8,
    parameter int Depth = 1024
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [clog2(Depth)-1:0]   wr_addr,
    input  logic [Width-1:0]          wr_data,
    input  logic [clog2(Depth)-1:0]   rd_addr,
    output logic [Width-1:0]          rd_data
);

    logic [Width-1:0] mem_r [Depth];

    // Synchronous write and registered read of the storage array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
        rd_data <= mem_r[rd_addr];
    end

endmodule

// File: rtl/trace_capture_ctrl.sv
// Trace capture sequencer: circular pre-trigger history, fixed post-trigger
// window, then oldest-first readout of the whole record on ready/valid.
module trace_capture_ctrl
    import trace_capture_ctrl_pkg::*;
#(
    parameter int Width   = 8,
    parameter int Depth   = 1024,
    parameter int PreTrig = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             trig,
    input  logic [Width-1:0] din_data,
    input  logic             din_valid,
    output logic [Width-1:0] dout_data,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic             busy,
    output logic             triggered
);

    localparam int AW      = clog2(Depth);
    localparam int CW      = clog2(Depth + 1);
    localparam int PostLen = Depth - PreTrig;

    localparam logic [AW-1:0] ADDR_LAST  = AW'(Depth - 1);
    localparam logic [AW-1:0] ADDR_ONE   = AW'(1);
    localparam logic [AW-1:0] CNT_PENULT = AW'(Depth - 2);
    localparam logic [CW-1:0] FILL_LAST  = CW'(PreTrig - 1);
    localparam logic [CW-1:0] POST_LAST  = CW'(PostLen - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    state_t          state_r, state_next_s;
    logic [AW-1:0]   wr_addr_r, rd_addr_r, rd_cnt_r, ram_raddr_s;
    logic [CW-1:0]   fill_cnt_r, post_cnt_r;
    logic            we_s, hs_s, trig_hit_s, enter_ro_s;
    logic            dout_valid_r, dout_last_r, busy_r, triggered_r;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        if (a == ADDR_LAST) begin
            return {AW{1'b0}};
        end else begin
            return a + ADDR_ONE;
        end
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and per-cycle strobes.
    always_comb begin
        state_next_s = state_r;
        we_s         = din_valid && (state_r inside {ST_PRE_FILL, ST_ARMED, ST_POST});
        hs_s         = dout_valid_r && dout_ready;
        trig_hit_s   = (state_r == ST_ARMED) && din_valid && trig;
        case (state_r)
            ST_IDLE: begin
                if (arm) state_next_s = ST_PRE_FILL;
                else     state_next_s = ST_IDLE;
            end
            ST_PRE_FILL: begin
                if (din_valid && (fill_cnt_r == FILL_LAST)) state_next_s = ST_ARMED;
                else                                        state_next_s = ST_PRE_FILL;
            end
            ST_ARMED: begin
                if (trig_hit_s) state_next_s = (PostLen == 1) ? ST_READOUT : ST_POST;
                else            state_next_s = ST_ARMED;
            end
            ST_POST: begin
                if (din_valid && (post_cnt_r == POST_LAST)) state_next_s = ST_READOUT;
                else                                        state_next_s = ST_POST;
            end
            ST_READOUT: begin
                if (hs_s && (rd_cnt_r == ADDR_LAST)) state_next_s = ST_IDLE;
                else                                 state_next_s = ST_READOUT;
            end
            default: state_next_s = ST_IDLE;
        endcase
        enter_ro_s = (state_r != ST_READOUT) && (state_next_s == ST_READOUT);
        // Next-address-when-consumed keeps the stream bubble-free.
        if (hs_s) ram_raddr_s = next_addr(rd_addr_r);
        else      ram_raddr_s = rd_addr_r;
    end

    // Pointers, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_r    <= {AW{1'b0}};
            rd_addr_r    <= {AW{1'b0}};
            rd_cnt_r     <= {AW{1'b0}};
            fill_cnt_r   <= {CW{1'b0}};
            post_cnt_r   <= {CW{1'b0}};
            dout_valid_r <= 1'b0;
            dout_last_r  <= 1'b0;
            busy_r       <= 1'b0;
            triggered_r  <= 1'b0;
        end else begin
            if (we_s) wr_addr_r <= next_addr(wr_addr_r);
            else      wr_addr_r <= wr_addr_r;

            if (state_r == ST_IDLE)                     fill_cnt_r <= {CW{1'b0}};
            else if (state_r == ST_PRE_FILL && din_valid) fill_cnt_r <= fill_cnt_r + CNT_ONE;
            else                                        fill_cnt_r <= fill_cnt_r;

            if (state_r == ST_IDLE)                   post_cnt_r <= {CW{1'b0}};
            else if (trig_hit_s)                      post_cnt_r <= CNT_ONE;
            else if (state_r == ST_POST && din_valid) post_cnt_r <= post_cnt_r + CNT_ONE;
            else                                      post_cnt_r <= post_cnt_r;

            // Oldest sample sits where the next write would have gone.
            if (enter_ro_s)                   rd_addr_r <= next_addr(wr_addr_r);
            else if (state_r == ST_READOUT)   rd_addr_r <= ram_raddr_s;
            else                              rd_addr_r <= rd_addr_r;

            if (state_r != ST_READOUT) rd_cnt_r <= {AW{1'b0}};
            else if (hs_s)             rd_cnt_r <= rd_cnt_r + ADDR_ONE;
            else                       rd_cnt_r <= rd_cnt_r;

            dout_valid_r <= (state_r == ST_READOUT) && (state_next_s == ST_READOUT);

            if ((state_r == ST_READOUT) && (state_next_s == ST_READOUT)) begin
                if (hs_s) dout_last_r <= (rd_cnt_r == CNT_PENULT);
                else      dout_last_r <= dout_last_r;
            end else begin
                dout_last_r <= 1'b0;
            end

            busy_r <= (state_next_s != ST_IDLE);

            if (trig_hit_s)                   triggered_r <= 1'b1;
            else if (state_next_s == ST_IDLE) triggered_r <= 1'b0;
            else                              triggered_r <= triggered_r;
        end
    end

    ram_1c_1r_1w #(
        .Width (Width),
        .Depth (Depth)
    ) u_ram (
        .clk     (clk),
        .wr_en   (we_s),
        .wr_addr (wr_addr_r),
        .wr_data (din_data),
        .rd_addr (ram_raddr_s),
        .rd_data (dout_data)
    );

    assign dout_valid = dout_valid_r;
    assign dout_last  = dout_last_r;
    assign busy       = busy_r;
    assign triggered  = triggered_r;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Bench for trace_capture_ctrl: three configurations driven from a scenario
// table plus random captures, checked against a queue-based record model.
module tb_trace_capture_ctrl;

    typedef struct {
        int sel;        // 0: D16/P4, 1: D16/P15, 2: D12/P5
        int tmode;      // 0: trig on value tval, 1: trig always, 2: random trig
        int tval;
        int vpct;       // din_valid probability (%)
        int rpct;       // dout_ready probability (%)
        int exp_first;  // expected readout index 0 (-1: not tabulated)
        int exp_trig;   // expected readout index PreTrig (-1: not tabulated)
        int abort_post; // reset after this many post samples (0: none)
        int abort_ro;   // reset after this many handshakes (0: none)
        bit arm_ro;     // pulse arm during readout and on the final handshake
    } vec_t;

    int depth_a [3] = '{16, 16, 12};
    int pre_a   [3] = '{4, 15, 5};

    logic       clk = 1'b0;
    logic       rst_a [3];
    logic       arm_a [3];
    logic       trig_a [3];
    logic [7:0] din_data_a [3];
    logic       din_valid_a [3];
    logic [7:0] dout_data_a [3];
    logic       dout_valid_a [3];
    logic       dout_ready_a [3];
    logic       dout_last_a [3];
    logic       busy_a [3];
    logic       triggered_a [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trace_capture_ctrl #(.Width(8), .Depth(16), .PreTrig(4)) dut0 (
        .clk(clk), .rst(rst_a[0]), .arm(arm_a[0]), .trig(trig_a[0]),
        .din_data(din_data_a[0]), .din_valid(din_valid_a[0]),
        .dout_data(dout_data_a[0]), .dout_valid(dout_valid_a[0]), .dout_ready(dout_ready_a[0]),
        .dout_last(dout_last_a[0]), .busy(busy_a[0]), .triggered(triggered_a[0]));

    trace_capture_ctrl #(.Width(8), .Depth(16), .PreTrig(15)) dut1 (
        .clk(clk), .rst(rst_a[1]), .arm(arm_a[1]), .trig(trig_a[1]),
        .din_data(din_data_a[1]), .din_valid(din_valid_a[1]),
        .dout_data(dout_data_a[1]), .dout_valid(dout_valid_a[1]), .dout_ready(dout_ready_a[1]),
        .dout_last(dout_last_a[1]), .busy(busy_a[1]), .triggered(triggered_a[1]));

    trace_capture_ctrl #(.Width(8), .Depth(12), .PreTrig(5)) dut2 (
        .clk(clk), .rst(rst_a[2]), .arm(arm_a[2]), .trig(trig_a[2]),
        .din_data(din_data_a[2]), .din_valid(din_valid_a[2]),
        .dout_data(dout_data_a[2]), .dout_valid(dout_valid_a[2]), .dout_ready(dout_ready_a[2]),
        .dout_last(dout_last_a[2]), .busy(busy_a[2]), .triggered(triggered_a[2]));

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    task automatic quiet(input int s);
        arm_a[s] = 1'b0; trig_a[s] = 1'b0; din_valid_a[s] = 1'b0;
        din_data_a[s] = 8'd0; dout_ready_a[s] = 1'b0;
    endtask

    // Pulse reset on one instance and confirm it lands in idle.
    task automatic reset_and_check(input int s);
        quiet(s);
        rst_a[s] = 1'b1;
        @(negedge clk);
        rst_a[s] = 1'b0;
        chk("rst_valid", int'(dout_valid_a[s]), 0);
        chk("rst_busy", int'(busy_a[s]), 0);
        chk("rst_triggered", int'(triggered_a[s]), 0);
        chk("rst_last", int'(dout_last_a[s]), 0);
        @(negedge clk);
        chk("rst_stays_idle", int'(busy_a[s]), 0);
    endtask

    task automatic run_capture(input vec_t v);
        int depth, pre, ramp, nwr, post, idx, budget, n_last;
        bit trg, done, stalled, r, dv, t;
        logic [7:0] d, held;
        logic [7:0] wr_q [$];
        depth = depth_a[v.sel];
        pre   = pre_a[v.sel];
        ramp  = (v.tmode == 2) ? int'($urandom_range(255)) : 0;
        nwr = 0; post = 0; trg = 1'b0; done = 1'b0; held = 8'd0;

        arm_a[v.sel] = 1'b1;
        @(negedge clk);
        arm_a[v.sel] = 1'b0;
        chk("busy_after_arm", int'(busy_a[v.sel]), 1);

        // Capture: the model records every accepted sample and applies the trigger rules.
        budget = 2000;
        while (!done && budget > 0) begin
            dv = ($urandom_range(99) < v.vpct);
            d  = 8'(ramp);
            ramp++;
            case (v.tmode)
                0:       t = (d == 8'(v.tval));
                1:       t = 1'b1;
                default: t = ($urandom_range(9) == 0);
            endcase
            din_valid_a[v.sel] = dv; din_data_a[v.sel] = d; trig_a[v.sel] = t;
            @(negedge clk);
            budget--;
            if (dv) begin
                wr_q.push_back(d);
                nwr++;
                if (trg) post++;
                else if (nwr > pre && t) begin
                    trg = 1'b1; post = 1;
                    chk("triggered_set", int'(triggered_a[v.sel]), 1);
                end
                if (trg && post == depth - pre) done = 1'b1;
            end
            if (!trg) chk("triggered_early", int'(triggered_a[v.sel]), 0);
            if (v.abort_post > 0 && trg && post == v.abort_post && !done) begin
                reset_and_check(v.sel);
                return;
            end
        end
        quiet(v.sel);
        if (!done) begin
            checks++; errors++;
            $display("FAIL capture_timeout sel=%0d writes=%0d", v.sel, nwr);
            reset_and_check(v.sel);
            return;
        end
        while (wr_q.size() > depth) void'(wr_q.pop_front());
        chk("ro_entry_valid", int'(dout_valid_a[v.sel]), 0);

        // Readout with random backpressure and ignored din traffic.
        idx = 0; stalled = 1'b0; n_last = 0; budget = depth * 40;
        while (idx < depth && budget > 0) begin
            din_valid_a[v.sel] = 1'($urandom_range(1));
            din_data_a[v.sel]  = 8'($urandom);
            @(negedge clk);
            budget--;
            if (v.abort_ro > 0 && idx == v.abort_ro) begin
                reset_and_check(v.sel);
                return;
            end
            chk("ro_valid", int'(dout_valid_a[v.sel]), 1);
            if (stalled) chk("stall_hold", int'(dout_data_a[v.sel]), int'(held));
            r = ($urandom_range(99) < v.rpct);
            dout_ready_a[v.sel] = r;
            arm_a[v.sel] = v.arm_ro && (idx == depth / 2 || idx == depth - 1);
            if (r) begin
                chk("ro_data", int'(dout_data_a[v.sel]), int'(wr_q[idx]));
                chk("ro_last", int'(dout_last_a[v.sel]), int'(idx == depth - 1));
                if (dout_last_a[v.sel]) n_last++;
                if (idx == 0) chk("ro_triggered", int'(triggered_a[v.sel]), 1);
                if (idx == 0 && v.exp_first >= 0) chk("ro_first_tab", int'(dout_data_a[v.sel]), v.exp_first);
                if (idx == pre && v.exp_trig >= 0) chk("ro_trig_tab", int'(dout_data_a[v.sel]), v.exp_trig);
                idx++;
                stalled = 1'b0;
            end else begin
                held = dout_data_a[v.sel];
                stalled = 1'b1;
            end
        end
        if (idx < depth) begin
            checks++; errors++;
            $display("FAIL readout_timeout sel=%0d got=%0d want=%0d", v.sel, idx, depth);
        end
        @(negedge clk);
        quiet(v.sel);
        chk("end_valid", int'(dout_valid_a[v.sel]), 0);
        chk("end_busy", int'(busy_a[v.sel]), 0);
        chk("end_triggered", int'(triggered_a[v.sel]), 0);
        chk("end_last", int'(dout_last_a[v.sel]), 0);
        chk("last_count", n_last, 1);
        @(negedge clk);
        chk("end_stays_idle", int'(busy_a[v.sel]), 0);
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{0, 0, 9,  100, 100, 5,  9,  0, 0, 1'b0};
        vecs[1] = '{0, 1, 0,  100, 100, 0,  4,  0, 0, 1'b0};
        vecs[2] = '{0, 0, 9,  100, 50,  5,  9,  0, 0, 1'b1};
        vecs[3] = '{1, 0, 20, 100, 100, 5,  20, 0, 0, 1'b0};
        vecs[4] = '{2, 0, 7,  100, 100, 2,  7,  0, 0, 1'b0};
        vecs[5] = '{2, 0, 30, 100, 100, 25, 30, 0, 0, 1'b0};
        vecs[6] = '{0, 0, 9,  100, 100, -1, -1, 3, 0, 1'b0};
        vecs[7] = '{0, 0, 9,  100, 100, -1, -1, 0, 5, 1'b0};
        vecs[8] = '{0, 0, 12, 100, 100, 8,  12, 0, 0, 1'b0};

        for (int s = 0; s < 3; s++) begin
            quiet(s);
            rst_a[s] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) rst_a[s] = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk("reset_valid", int'(dout_valid_a[s]), 0);
            chk("reset_last", int'(dout_last_a[s]), 0);
            chk("reset_busy", int'(busy_a[s]), 0);
            chk("reset_triggered", int'(triggered_a[s]), 0);
        end

        for (int i = 0; i < 9; i++) run_capture(vecs[i]);

        for (int i = 0; i < 12; i++) begin
            vec_t rv;
            rv = '{int'($urandom_range(2)), 2, 0, 70, 60, -1, -1, 0, 0, 1'b0};
            run_capture(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
